// File: rtl/nam85_pkg.sv
// nam85_pkg: shared register indices, regfile ext-op/pair codes and stack sequencer states
package nam85_pkg;
    localparam logic [3:0] R_B  = 4'd0;
    localparam logic [3:0] R_C  = 4'd1;
    localparam logic [3:0] R_D  = 4'd2;
    localparam logic [3:0] R_E  = 4'd3;
    localparam logic [3:0] R_H  = 4'd4;
    localparam logic [3:0] R_L  = 4'd5;
    localparam logic [3:0] R_A  = 4'd6;
    localparam logic [3:0] R_F  = 4'd7;
    localparam logic [3:0] R_SP = 4'd8;
    localparam logic [3:0] R_PC = 4'd10;
    localparam logic [1:0] EXT_NONE = 2'b00;
    localparam logic [1:0] EXT_INC  = 2'b01;
    localparam logic [1:0] EXT_DCR  = 2'b10;
    localparam logic [1:0] EXT_INC2 = 2'b11;
    localparam logic [1:0] RP_BC  = 2'b00;
    localparam logic [1:0] RP_DE  = 2'b01;
    localparam logic [1:0] RP_HL  = 2'b10;
    localparam logic [1:0] RP_PSW = 2'b11;
    localparam logic STK_PUSH = 1'b0;
    localparam logic STK_POP  = 1'b1;
    typedef enum logic [3:0] {
        S_IDLE, S_RD_SP, S_RD_RP, S_WR_HI, S_WR_LO, S_RD_LO, S_RD_HI, S_WR_RP, S_UPD
    } stk_state_t;
    function automatic logic [3:0] pair_idx(input logic [1:0] rp);
        return {1'b0, rp, 1'b0};
    endfunction
endpackage

// File: rtl/stack_engine.sv
// stack_engine: multi-cycle PUSH/POP sequencer between control unit, regfile and memory bus
module stack_engine
    import nam85_pkg::*;
#(
    parameter logic [3:0] SP_IDX = R_SP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [1:0]  cmd_rp,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rf_read_sel,
    output logic [4:0]  rf_write_sel,
    output logic        rf_write_en,
    output logic [1:0]  rf_ext_op,
    output logic [15:0] rf_data_in,
    input  logic [15:0] rf_out,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready
);
    stk_state_t  state;
    logic        op_q;
    logic [1:0]  rp_q;
    logic [15:0] sp_q;
    logic [7:0]  val_q;
    logic [7:0]  lo_q;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    // Sequencer: every output is set on the edge entering the state that needs it, memory states hold until mem_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            op_q         <= STK_PUSH;
            rp_q         <= RP_BC;
            sp_q         <= '0;
            val_q        <= '0;
            lo_q         <= '0;
            done         <= 1'b0;
            rf_read_sel  <= '0;
            rf_write_sel <= '0;
            rf_write_en  <= 1'b0;
            rf_ext_op    <= EXT_NONE;
            rf_data_in   <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_we       <= 1'b0;
            mem_re       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (cmd_valid) begin
                    op_q        <= cmd_op;
                    rp_q        <= cmd_rp;
                    rf_read_sel <= {1'b1, SP_IDX};
                    state       <= S_RD_SP;
                end
                S_RD_SP: begin
                    sp_q <= rf_out;
                    if (op_q == STK_PUSH) begin
                        rf_read_sel <= {1'b1, pair_idx(rp_q)};
                        state       <= S_RD_RP;
                    end else begin
                        rf_read_sel <= '0;
                        mem_addr    <= rf_out;
                        mem_re      <= 1'b1;
                        state       <= S_RD_LO;
                    end
                end
                S_RD_RP: begin
                    val_q       <= rf_out[7:0];
                    rf_read_sel <= '0;
                    mem_addr    <= sp_q - 16'd1;
                    mem_wdata   <= rf_out[15:8];
                    mem_we      <= 1'b1;
                    state       <= S_WR_HI;
                end
                S_WR_HI: if (mem_ready) begin
                    mem_addr  <= sp_q - 16'd2;
                    mem_wdata <= val_q;
                    state     <= S_WR_LO;
                end
                S_WR_LO: if (mem_ready) begin
                    mem_we       <= 1'b0;
                    mem_addr     <= '0;
                    mem_wdata    <= '0;
                    rf_write_en  <= 1'b1;
                    rf_write_sel <= {1'b1, SP_IDX};
                    rf_data_in   <= sp_q - 16'd2;
                    state        <= S_UPD;
                end
                S_RD_LO: if (mem_ready) begin
                    lo_q     <= mem_rdata;
                    mem_addr <= sp_q + 16'd1;
                    state    <= S_RD_HI;
                end
                S_RD_HI: if (mem_ready) begin
                    mem_re       <= 1'b0;
                    mem_addr     <= '0;
                    rf_write_en  <= 1'b1;
                    rf_write_sel <= {1'b1, pair_idx(rp_q)};
                    rf_data_in   <= {mem_rdata, lo_q};
                    state        <= S_WR_RP;
                end
                S_WR_RP: begin
                    rf_write_en  <= 1'b0;
                    rf_data_in   <= '0;
                    rf_write_sel <= {1'b1, SP_IDX};
                    rf_ext_op    <= EXT_INC2;
                    state        <= S_UPD;
                end
                S_UPD: begin
                    rf_write_en  <= 1'b0;
                    rf_ext_op    <= EXT_NONE;
                    rf_write_sel <= '0;
                    rf_data_in   <= '0;
                    done         <= 1'b1;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stack_engine.sv
// tb_stack_engine: directed PUSH/POP vectors against a regfile/memory world and a pair-level stack model
module tb_stack_engine;
    import nam85_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_op, busy, done;
    logic [1:0]  cmd_rp;
    logic [4:0]  rf_read_sel, rf_write_sel;
    logic        rf_write_en;
    logic [1:0]  rf_ext_op;
    logic [15:0] rf_data_in, rf_out, mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_we, mem_re, mem_ready;

    stack_engine dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rp(cmd_rp), .busy(busy), .done(done), .rf_read_sel(rf_read_sel),
        .rf_write_sel(rf_write_sel), .rf_write_en(rf_write_en), .rf_ext_op(rf_ext_op),
        .rf_data_in(rf_data_in), .rf_out(rf_out), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int exp_done = -1;
    int vectors = 0;
    int errors = 0;

    logic [7:0]  w_rf [0:15];
    logic [7:0]  w_mem [0:65535];
    logic        pre_we;
    logic [3:0]  pre_idx;
    logic [15:0] pre_val;
    logic [7:0]  m_rf [0:15];
    logic [7:0]  m_mem [logic [15:0]];

    logic [3:0]  wi, wi1;
    logic [15:0] wcur, wext;
    assign wi   = rf_write_sel[3:0];
    assign wi1  = wi + 4'd1;
    assign wcur = {w_rf[wi], w_rf[wi1]};
    assign wext = rf_ext_op == 2'b01 ? wcur + 16'd1 : rf_ext_op == 2'b10 ? wcur - 16'd1 : wcur + 16'd2;
    assign rf_out    = {w_rf[rf_read_sel[3:0]], w_rf[rf_read_sel[3:0] + 4'd1]};
    assign mem_rdata = w_mem[mem_addr];

    always @(posedge clk) cyc <= cyc + 1;

    // Regfile and memory the engine talks to; ext_op wins over a pair write
    always @(posedge clk) begin
        if (pre_we) begin
            w_rf[pre_idx]        <= pre_val[15:8];
            w_rf[pre_idx + 4'd1] <= pre_val[7:0];
        end else if (rf_ext_op != 2'b00)
            {w_rf[wi], w_rf[wi1]} <= wext;
        else if (rf_write_en)
            {w_rf[wi], w_rf[wi1]} <= rf_data_in;
        if (mem_we && mem_ready) w_mem[mem_addr] <= mem_wdata;
    end

    // Completion is due six cycles after acceptance plus one per stalled memory cycle
    always @(posedge clk) begin
        if (rst) exp_done <= -1;
        else if (cmd_valid && cmd_ready) exp_done <= cyc + 6;
        else if ((mem_we || mem_re) && !mem_ready) exp_done <= exp_done + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            chk("done_timing", 32'(done), 32'(cyc == exp_done));
            chk("busy_vs_ready", 32'(busy), 32'(!cmd_ready));
            chk("ext_we_exclusive", 32'(rf_write_en && rf_ext_op != 2'b00), 0);
        end
    endtask

    function automatic logic [15:0] wpair(input logic [3:0] i);
        return {w_rf[i], w_rf[i + 4'd1]};
    endfunction

    function automatic logic [15:0] mpair(input logic [3:0] i);
        return {m_rf[i], m_rf[i + 4'd1]};
    endfunction

    task automatic mset(input logic [3:0] i, input logic [15:0] v);
        m_rf[i] = v[15:8];
        m_rf[i + 4'd1] = v[7:0];
    endtask

    task automatic model_push(input logic [1:0] rp);
        logic [15:0] sp = mpair(R_SP);
        logic [15:0] v = mpair({1'b0, rp, 1'b0});
        m_mem[sp - 16'd1] = v[15:8];
        m_mem[sp - 16'd2] = v[7:0];
        mset(R_SP, sp - 16'd2);
    endtask

    task automatic model_pop(input logic [1:0] rp);
        logic [15:0] sp = mpair(R_SP);
        mset({1'b0, rp, 1'b0}, {m_mem[sp + 16'd1], m_mem[sp]});
        mset(R_SP, sp + 16'd2);
    endtask

    task automatic set_pair(input logic [3:0] i, input logic [15:0] v);
        pre_idx = i;
        pre_val = v;
        pre_we  = 1'b1;
        mset(i, v);
        tick();
        pre_we = 1'b0;
    endtask

    task automatic issue(input logic op, input logic [1:0] rp, output int acc);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rp    = rp;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        chk("accept_ready", 32'(cmd_ready), 1);
        acc = cyc;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int dc, output int n_inc2);
        int n = 0;
        n_inc2 = 0;
        while (!done && n < 40) begin
            if (rf_ext_op == 2'b11) n_inc2++;
            tick();
            n++;
        end
        chk("done_seen", 32'(done), 1);
        dc = cyc;
    endtask

    task automatic chk_model(input logic [3:0] pair);
        chk("sp_model", 32'(wpair(R_SP)), 32'(mpair(R_SP)));
        chk("pair_model", 32'(wpair(pair)), 32'(mpair(pair)));
    endtask

    task automatic chk_mem(input logic [15:0] a, input logic [7:0] lit);
        chk("mem_model", 32'(w_mem[a]), 32'(m_mem[a]));
        chk("mem_literal", 32'(w_mem[a]), 32'(lit));
    endtask

    initial begin
        int acc, acc2, dc, n2, n;
        logic [15:0] a;
        logic [7:0]  d;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_rp = 2'b00; mem_ready = 1'b1;
        pre_we = 1'b0; pre_idx = '0; pre_val = '0;
        for (int i = 0; i < 16; i++) m_rf[i] = 8'h00;
        repeat (2) tick();
        chk("rst_strobes", {busy, done, mem_we, mem_re, rf_write_en, rf_ext_op}, 0);
        chk("rst_sel", {rf_read_sel, rf_write_sel}, 0);
        chk("rst_data", {rf_data_in, mem_addr}, 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", {cmd_ready, busy, done}, 3'b100);

        set_pair(R_B, 16'h1234);
        set_pair(R_SP, 16'h2000);
        issue(STK_PUSH, RP_BC, acc);
        wait_done(dc, n2);
        chk("push_latency", dc - acc, 6);
        model_push(RP_BC);
        chk_model(R_B);
        chk("push_sp_literal", 32'(wpair(R_SP)), 32'h1FFE);
        chk_mem(16'h1FFF, 8'h12);
        chk_mem(16'h1FFE, 8'h34);

        issue(STK_POP, RP_DE, acc);
        wait_done(dc, n2);
        chk("pop_latency", dc - acc, 6);
        chk("pop_inc2_cycles", n2, 1);
        model_pop(RP_DE);
        chk_model(R_D);
        chk("pop_de_literal", 32'(wpair(R_D)), 32'h1234);
        chk("pop_sp_literal", 32'(wpair(R_SP)), 32'h2000);

        set_pair(R_H, 16'hABCD);
        set_pair(R_SP, 16'h0000);
        issue(STK_PUSH, RP_HL, acc);
        wait_done(dc, n2);
        model_push(RP_HL);
        chk_model(R_H);
        chk("wrap_push_sp", 32'(wpair(R_SP)), 32'hFFFE);
        chk_mem(16'hFFFF, 8'hAB);
        chk_mem(16'hFFFE, 8'hCD);
        issue(STK_POP, RP_PSW, acc);
        wait_done(dc, n2);
        model_pop(RP_PSW);
        chk_model(R_A);
        chk("psw_a", 32'(w_rf[R_A]), 32'hAB);
        chk("psw_f", 32'(w_rf[R_F]), 32'hCD);
        chk("wrap_pop_sp", 32'(wpair(R_SP)), 32'h0000);

        issue(STK_PUSH, RP_BC, acc);
        n = 0;
        while (!mem_we && n < 10) begin
            tick();
            n++;
        end
        mem_ready = 1'b0;
        a = mem_addr;
        d = mem_wdata;
        chk("stall_addr", 32'(a), 32'hFFFF);
        chk("stall_wdata", 32'(d), 32'h12);
        repeat (3) begin
            tick();
            chk("stall_hold", {mem_we, mem_addr, mem_wdata}, {1'b1, a, d});
        end
        mem_ready = 1'b1;
        wait_done(dc, n2);
        chk("stall_latency", dc - acc, 9);
        model_push(RP_BC);
        chk_model(R_B);
        chk_mem(16'hFFFF, 8'h12);
        chk_mem(16'hFFFE, 8'h34);

        mem_ready = 1'b0;
        issue(STK_POP, RP_HL, acc);
        n = 0;
        while (!mem_re && n < 10) begin
            tick();
            n++;
        end
        tick();
        chk("in_rd_lo", {busy, mem_re}, 2'b11);
        rst = 1'b1;
        tick();
        chk("midrst_strobes", {busy, done, mem_we, mem_re, rf_write_en, rf_ext_op}, 0);
        chk_model(R_H);
        chk("midrst_sp", 32'(wpair(R_SP)), 32'hFFFE);
        rst = 1'b0;
        mem_ready = 1'b1;
        tick();
        chk("midrst_ready", {cmd_ready, busy}, 2'b10);

        set_pair(R_D, 16'hBEEF);
        set_pair(R_SP, 16'h0001);
        cmd_valid = 1'b1; cmd_op = STK_PUSH; cmd_rp = RP_DE;
        acc = cyc;
        tick();
        cmd_op = STK_POP; cmd_rp = RP_BC;
        wait_done(dc, n2);
        chk("b2b_first_latency", dc - acc, 6);
        chk("b2b_ready_in_done", 32'(cmd_ready), 1);
        model_push(RP_DE);
        acc2 = cyc;
        tick();
        cmd_valid = 1'b0;
        chk("b2b_second_busy", 32'(busy), 1);
        wait_done(dc, n2);
        chk("b2b_second_latency", dc - acc2, 6);
        model_pop(RP_BC);
        chk_model(R_B);
        chk("b2b_bc_literal", 32'(wpair(R_B)), 32'hBEEF);
        chk("b2b_sp_literal", 32'(wpair(R_SP)), 32'h0001);
        chk_mem(16'h0000, 8'hBE);
        chk_mem(16'hFFFF, 8'hEF);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
